arduino_bus_arbiter: RTL and testbench

ARDUINO_BUS_ARBITER -- requirements
Module: arduino_bus_arbiter

---
 rtl/arduino_bus_arbiter.sv | 152 +++++++++++++++
 tb/tb_arduino_bus_arbiter.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/arduino_bus_arbiter.sv
// Round-robin bus arbiter for four Arduino nodes; the FSM advances only on tick pulses.
// Optional macro ARDUINO_ARB_TIMEOUT_EN adds a WAIT-state timeout with an ABORT path.
module arduino_bus_arbiter #(
    parameter int unsigned TIMEOUT_TICKS = 8
) (
    input  logic       clock50,
    input  logic       reset_n,
    input  logic       tick,
    input  logic [3:0] req,
    input  logic [7:0] node_data,
    input  logic [1:0] node_resp,
    output logic [3:0] grant,
    output logic [1:0] bus_addr,
    output logic [1:0] bus_data,
    output logic       busy,
    output logic       done,
    output logic       timeout,
    output logic [3:0] display
);

    typedef enum logic [2:0] {StIdle, StGrant, StWait, StDone, StAbort} state_t;

    if (TIMEOUT_TICKS < 1 || TIMEOUT_TICKS > 255) begin : g_bad_timeout
        $error("TIMEOUT_TICKS must be in 1..255");
    end

    state_t     state_q, state_d;
    logic [3:0] grant_q, grant_d;
    logic [1:0] addr_q, addr_d;
    logic [1:0] data_q, data_d;
    logic       done_q, done_d;
    logic [3:0] display_q, display_d;
    logic [1:0] ptr_q, ptr_d;
    logic [1:0] win;

`ifdef ARDUINO_ARB_TIMEOUT_EN
    localparam logic [7:0] TimeoutLim = 8'(TIMEOUT_TICKS);
    logic [7:0] cnt_q, cnt_d, cnt_inc;
    logic       timeout_q, timeout_d;

    assign cnt_inc = (cnt_q == 8'hff) ? cnt_q : cnt_q + 8'd1;
`endif

    // Highest-priority candidate is ptr+1, so it is assigned last.
    always_comb begin
        win = 2'd0;
        for (int i = 4; i >= 1; i--) begin
            if (req[ptr_q + 2'(i)]) win = ptr_q + 2'(i);
        end
    end

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        addr_d    = addr_q;
        data_d    = data_q;
        display_d = display_q;
        ptr_d     = ptr_q;
        done_d    = 1'b0;
`ifdef ARDUINO_ARB_TIMEOUT_EN
        cnt_d     = cnt_q;
        timeout_d = 1'b0;
`endif
        if (tick) begin
            unique case (state_q)
                StIdle: begin
                    if (req != 4'b0000) begin
                        state_d = StGrant;
                        grant_d = 4'b0001 << win;
                        addr_d  = win;
                        data_d  = node_data[{win, 1'b0} +: 2];
                    end
                end
                StGrant: begin
                    state_d = StWait;
`ifdef ARDUINO_ARB_TIMEOUT_EN
                    cnt_d   = 8'd0;
`endif
                end
                StWait: begin
                    if (node_resp != 2'b00) begin
                        state_d   = StDone;
                        done_d    = 1'b1;
                        display_d = {addr_q, node_resp};
                        ptr_d     = addr_q;
                    end
`ifdef ARDUINO_ARB_TIMEOUT_EN
                    else if (cnt_inc >= TimeoutLim) begin
                        state_d   = StAbort;
                        timeout_d = 1'b1;
                        ptr_d     = addr_q;
                        cnt_d     = cnt_inc;
                    end else begin
                        cnt_d = cnt_inc;
                    end
`endif
                end
                StDone, StAbort: begin
                    state_d = StIdle;
                    grant_d = 4'b0000;
                    addr_d  = 2'd0;
                    data_d  = 2'd0;
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clock50 or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= StIdle;
            grant_q   <= 4'b0000;
            addr_q    <= 2'd0;
            data_q    <= 2'd0;
            done_q    <= 1'b0;
            display_q <= 4'b0000;
            ptr_q     <= 2'd3;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            done_q    <= done_d;
            display_q <= display_d;
            ptr_q     <= ptr_d;
        end
    end

`ifdef ARDUINO_ARB_TIMEOUT_EN
    always_ff @(posedge clock50 or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q     <= 8'd0;
            timeout_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
        end
    end

    assign timeout = timeout_q;
`else
    assign timeout = 1'b0;
`endif

    assign grant    = grant_q;
    assign bus_addr = addr_q;
    assign bus_data = data_q;
    assign busy     = (state_q != StIdle);
    assign done     = done_q;
    assign display  = display_q;

endmodule

// File: tb/tb_arduino_bus_arbiter.sv
// Randomised scoreboard bench for arduino_bus_arbiter; a transaction-level model predicts
// each completed or aborted transfer and a monitor checks it when done/timeout pulses.
module tb_arduino_bus_arbiter;

    localparam int unsigned TO = 8;

    logic       clock50 = 1'b0;
    logic       reset_n;
    logic       tick;
    logic [3:0] req;
    logic [7:0] node_data;
    logic [1:0] node_resp;
    logic [3:0] grant;
    logic [1:0] bus_addr;
    logic [1:0] bus_data;
    logic       busy;
    logic       done;
    logic       timeout;
    logic [3:0] display;

    arduino_bus_arbiter #(.TIMEOUT_TICKS(TO)) dut (
        .clock50   (clock50),
        .reset_n   (reset_n),
        .tick      (tick),
        .req       (req),
        .node_data (node_data),
        .node_resp (node_resp),
        .grant     (grant),
        .bus_addr  (bus_addr),
        .bus_data  (bus_data),
        .busy      (busy),
        .done      (done),
        .timeout   (timeout),
        .display   (display)
    );

    always #5 clock50 = ~clock50;

    typedef struct {
        bit         is_abort;
        logic [3:0] grant;
        logic [1:0] addr;
        logic [1:0] data;
        logic [3:0] disp;
    } exp_t;

    exp_t       sb[$];
    exp_t       mon_e;
    int         checks = 0;
    int         errors = 0;
    int         m_ptr;
    logic [3:0] m_disp;
    logic       prev_done = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Monitor: every done/timeout pulse must match the oldest predicted transfer.
    always @(negedge clock50) begin
        if (prev_done === 1'b1) check("done_one_cycle", done, 0);
        prev_done = done;
        if (done === 1'b1 || timeout === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_pulse done=%b timeout=%b", done, timeout);
            end else begin
                mon_e = sb.pop_front();
                check("pulse_timeout", timeout, mon_e.is_abort);
                check("pulse_done", done, !mon_e.is_abort);
                check("end_grant", grant, mon_e.grant);
                check("end_bus_addr", bus_addr, mon_e.addr);
                check("end_bus_data", bus_data, mon_e.data);
                check("end_display", display, mon_e.disp);
                check("end_busy", busy, 1);
            end
        end
    end

    task automatic cyc(input bit t);
        tick = t;
        @(negedge clock50);
        tick = 1'b0;
    endtask

    task automatic gap(input bit drop);
        repeat ($urandom_range(0, 2)) begin
            node_resp = 2'($urandom);
            node_data = 8'($urandom);
            req       = drop ? 4'b0000 : 4'($urandom);
            cyc(0);
        end
    endtask

    function automatic int pick(input logic [3:0] r, input int p);
        for (int i = 1; i <= 4; i++) begin
            if (r[(p + i) % 4]) return (p + i) % 4;
        end
        return -1;
    endfunction

    task automatic check_reset_values();
        check("rst_grant", grant, 0);
        check("rst_bus_addr", bus_addr, 0);
        check("rst_bus_data", bus_data, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_timeout", timeout, 0);
        check("rst_display", display, 0);
    endtask

    // Called at a falling edge; reset lands mid-cycle to exercise its asynchronous path.
    task automatic do_reset();
        #2 reset_n = 1'b0;
        #1 check_reset_values();
        @(negedge clock50);
        @(negedge clock50);
        reset_n = 1'b1;
        m_ptr   = 3;
        m_disp  = 4'b0000;
    endtask

    // One full transfer: node responds with rv on the k-th WAIT tick.
    task automatic xfer(input logic [3:0] r, input logic [7:0] d, input int k,
                        input logic [1:0] rv, input bit drop);
        int         w;
        int         j;
        bit         fin;
        bit         ab;
        exp_t       e;
        logic [3:0] g;
        logic [1:0] dd;
        req       = r;
        node_data = d;
        node_resp = 2'($urandom);
        cyc(1);
        w = pick(r, m_ptr);
        if (w < 0) begin
            check("idle_no_req_grant", grant, 0);
            check("idle_no_req_busy", busy, 0);
            return;
        end
        g  = 4'b0001 << w;
        dd = d[2*w +: 2];
        check("grant_latch", grant, g);
        check("addr_latch", bus_addr, w);
        check("data_latch", bus_data, dd);
        check("busy_grant", busy, 1);
        gap(drop);
        req       = drop ? 4'b0000 : 4'($urandom);
        node_resp = 2'($urandom);
        cyc(1);
        check("grant_hold_enter_wait", grant, g);
        j = 0;
        fin = 1'b0;
        while (!fin) begin
            j++;
            ab = 1'b0;
            gap(drop);
            req       = drop ? 4'b0000 : 4'($urandom);
            node_data = 8'($urandom);
            node_resp = (j == k) ? rv : 2'b00;
`ifdef ARDUINO_ARB_TIMEOUT_EN
            if (j == k) fin = 1'b1;
            else if (j == int'(TO)) begin
                fin = 1'b1;
                ab  = 1'b1;
            end
`else
            fin = (j == k);
`endif
            if (fin) begin
                e.is_abort = ab;
                e.grant    = g;
                e.addr     = 2'(w);
                e.data     = dd;
                e.disp     = ab ? m_disp : {2'(w), rv};
                sb.push_back(e);
                m_disp = e.disp;
                m_ptr  = w;
            end
            cyc(1);
            check("grant_hold_wait", grant, g);
            check("addr_hold_wait", bus_addr, w);
        end
        gap(drop);
        cyc(1);
        check("idle_grant_cleared", grant, 0);
        check("idle_addr_cleared", bus_addr, 0);
        check("idle_data_cleared", bus_data, 0);
        check("idle_busy_low", busy, 0);
    endtask

    initial begin
        reset_n   = 1'b0;
        tick      = 1'b0;
        req       = 4'b0000;
        node_data = 8'h00;
        node_resp = 2'b00;
        m_ptr     = 3;
        m_disp    = 4'b0000;
        @(negedge clock50);
        check_reset_values();
        @(negedge clock50);
        reset_n = 1'b1;

        // No tick: nothing may happen even with a pending request.
        req = 4'b0001;
        repeat (8) cyc(0);
        check("no_tick_grant", grant, 0);
        check("no_tick_busy", busy, 0);

        xfer(4'b0001, 8'b0000_0010, 1, 2'b01, 1'b0);
        check("basic_display", display, 4'b0001);

        do_reset();
        for (int n = 0; n < 5; n++) xfer(4'b1111, 8'($urandom), 1, 2'b11, 1'b0);

        xfer(4'b0010, 8'($urandom), 2, 2'b10, 1'b1);
        check("drop_req_display", display, 4'b0110);

`ifdef ARDUINO_ARB_TIMEOUT_EN
        xfer(4'b0100, 8'($urandom), int'(TO) + 5, 2'b01, 1'b0);
        check("abort_display_kept", display, 4'b0110);
        xfer(4'b1111, 8'($urandom), 1, 2'b01, 1'b0);
`endif

        // Reset in WAIT while node 3 holds the bus.
        req = 4'b1000;
        cyc(1);
        cyc(1);
        node_resp = 2'b00;
        cyc(1);
        cyc(1);
        check("pre_reset_grant", grant, 4'b1000);
        do_reset();
        check("reset_sb_empty", sb.size(), 0);
        xfer(4'b1001, 8'($urandom), 1, 2'b01, 1'b0);

        for (int n = 0; n < 40; n++) begin
            xfer(4'($urandom), 8'($urandom), $urandom_range(1, TO + 3),
                 2'($urandom_range(1, 3)), $urandom_range(0, 3) == 0);
        end

        repeat (3) cyc(0);
        check("scoreboard_drained", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
